// File: rtl/sparc_mem_pkg.sv
// Shared encodings for the MFA/MFC memory responder.
//   SZ_*     : access size field encodings
//   RW_*     : direction encodings (1 = read, 0 = write)
//   state_e  : responder FSM states
package sparc_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_align_unit.sv
// Combinational alignment/check unit for big-endian byte/half/word accesses.
// Ports:
//   i_addr     : request byte address
//   i_size     : access size (SZ_*)
//   i_signed   : sign-extend narrow reads
//   i_wr_data  : write data, right-justified (byte in [7:0], half in [15:0])
//   i_rd_bytes : {ram[a], ram[a+1], ram[a+2], ram[a+3]}
//   o_lane_en  : lane write enables, bit 3 = ram[a] ... bit 0 = ram[a+3]; zero on error
//   o_wr_bytes : write bytes in the same lane order as i_rd_bytes
//   o_err      : misaligned, out-of-range or illegal size
//   o_rd_data  : extended read data (zero on error)
module mem_align_unit
  import sparc_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_rd_bytes,
  output logic [3:0]  o_lane_en,
  output logic [31:0] o_wr_bytes,
  output logic        o_err,
  output logic [31:0] o_rd_data
);

  logic [1:0]  w_span;
  logic        w_misalign;
  logic [32:0] w_end;

  always_comb begin
    w_span     = 2'd0;
    w_misalign = 1'b0;
    o_lane_en  = 4'b0000;
    o_wr_bytes = 32'd0;
    o_rd_data  = 32'd0;
    case (i_size)
      SZ_BYTE: begin
        o_lane_en  = 4'b1000;
        o_wr_bytes = {i_wr_data[7:0], 24'd0};
        o_rd_data  = i_signed ? {{24{i_rd_bytes[31]}}, i_rd_bytes[31:24]}
                              : {24'd0, i_rd_bytes[31:24]};
      end
      SZ_HALF: begin
        w_span     = 2'd1;
        w_misalign = i_addr[0];
        o_lane_en  = 4'b1100;
        o_wr_bytes = {i_wr_data[15:0], 16'd0};
        o_rd_data  = i_signed ? {{16{i_rd_bytes[31]}}, i_rd_bytes[31:16]}
                              : {16'd0, i_rd_bytes[31:16]};
      end
      SZ_WORD: begin
        w_span     = 2'd3;
        w_misalign = (i_addr[1:0] != 2'b00);
        o_lane_en  = 4'b1111;
        o_wr_bytes = i_wr_data;
        o_rd_data  = i_rd_bytes;
      end
      default: ;
    endcase

    // Last byte touched, computed at 33 bits so upper address bits also trip the range check.
    w_end = {1'b0, i_addr} + {31'd0, w_span};
    o_err = w_misalign || (w_end >= 33'(DEPTH)) || (i_size == SZ_ILL);

    if (o_err) begin
      o_lane_en = 4'b0000;
      o_rd_data = 32'd0;
    end
  end

endmodule

// File: rtl/sparc_mem_responder.sv
// Memory-side responder for the CU's MFA/MFC 4-phase handshake.
// Ports:
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset (ram contents are kept)
//   i_mfa       : level request, held until o_mfc seen
//   i_rw        : 1 = read, 0 = write
//   i_size      : 00 byte, 01 half, 10 word, 11 illegal
//   i_signed    : sign-extend narrow reads
//   i_addr      : byte address
//   i_data_in   : write data, right-justified
//   o_data_out  : read data while o_mfc=1, else 0
//   o_mfc       : memory function complete
//   o_mem_err   : qualifies o_mfc with an access error
module sparc_mem_responder
  import sparc_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mfa,
  input  logic        i_rw,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_mfc,
  output logic        o_mem_err
);

  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [7:0] ram [0:DEPTH-1];

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rw;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_data_out;
  logic          r_mfc;
  logic          r_mem_err;

  logic          w_rw;
  logic [1:0]    w_size;
  logic          w_signed;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_idx [4];
  logic [31:0]   w_rd_bytes;
  logic [3:0]    w_lane_en;
  logic [31:0]   w_wr_bytes;
  logic          w_err;
  logic [31:0]   w_rd_data;
  logic          w_enter_done;

  // In IDLE the live inputs are used so a zero-wait request can complete on its accept edge.
  assign w_rw     = (r_state == ST_IDLE) ? i_rw      : r_rw;
  assign w_size   = (r_state == ST_IDLE) ? i_size    : r_size;
  assign w_signed = (r_state == ST_IDLE) ? i_signed  : r_signed;
  assign w_addr   = (r_state == ST_IDLE) ? i_addr    : r_addr;
  assign w_wdata  = (r_state == ST_IDLE) ? i_data_in : r_wdata;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = w_addr[AW-1:0] + AW'(k);
    end
  end

  assign w_rd_bytes = {ram[w_idx[0]], ram[w_idx[1]], ram[w_idx[2]], ram[w_idx[3]]};

  mem_align_unit #(
    .DEPTH (DEPTH)
  ) u_align (
    .i_addr     (w_addr),
    .i_size     (w_size),
    .i_signed   (w_signed),
    .i_wr_data  (w_wdata),
    .i_rd_bytes (w_rd_bytes),
    .o_lane_en  (w_lane_en),
    .o_wr_bytes (w_wr_bytes),
    .o_err      (w_err),
    .o_rd_data  (w_rd_data)
  );

  // Edge on which DONE is entered; reset qualifies it so the un-reset ram never commits.
  always_comb begin
    w_enter_done = 1'b0;
    if (i_rst_n && i_mfa) begin
      if (r_state == ST_IDLE) begin
        w_enter_done = (WAIT_STATES == 0);
      end else if (r_state == ST_WAIT) begin
        w_enter_done = (r_cnt == CW'(1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_enter_done && (w_rw == RW_WRITE)) begin
      for (int k = 0; k < 4; k++) begin
        if (w_lane_en[3-k]) begin
          ram[w_idx[k]] <= w_wr_bytes[31-8*k -: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rw       <= RW_READ;
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_data_out <= 32'd0;
      r_mfc      <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      if (w_enter_done) begin
        r_state    <= ST_DONE;
        r_mfc      <= 1'b1;
        r_mem_err  <= w_err;
        r_data_out <= (!w_err && (w_rw == RW_READ)) ? w_rd_data : 32'd0;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_mfa) begin
            r_rw     <= i_rw;
            r_size   <= i_size;
            r_signed <= i_signed;
            r_addr   <= i_addr;
            r_wdata  <= i_data_in;
            r_cnt    <= CW'(WAIT_STATES);
            if (!w_enter_done) begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!i_mfa) begin
            r_state <= ST_IDLE;
          end else if (!w_enter_done) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          if (!i_mfa) begin
            r_state    <= ST_IDLE;
            r_mfc      <= 1'b0;
            r_mem_err  <= 1'b0;
            r_data_out <= 32'd0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_data_out = r_data_out;
  assign o_mfc      = r_mfc;
  assign o_mem_err  = r_mem_err;

endmodule

// File: tb/tb_sparc_mem_responder.sv
// Directed bench for sparc_mem_responder: one instance with two wait states, one with none.
module tb_sparc_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mfa = 1'b0;
  logic        mfa0 = 1'b0;
  logic        rw = 1'b1;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] dout, dout0;
  logic        mfc, mfc0, err, err0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sparc_mem_responder #(
    .DEPTH       (512),
    .AW          (9),
    .WAIT_STATES (2)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_mfa      (mfa),
    .i_rw       (rw),
    .i_size     (size),
    .i_signed   (sgn),
    .i_addr     (addr),
    .i_data_in  (wdata),
    .o_data_out (dout),
    .o_mfc      (mfc),
    .o_mem_err  (err)
  );

  sparc_mem_responder #(
    .DEPTH       (512),
    .AW          (9),
    .WAIT_STATES (0)
  ) dut0 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_mfa      (mfa0),
    .i_rw       (rw),
    .i_size     (size),
    .i_signed   (sgn),
    .i_addr     (addr),
    .i_data_in  (wdata),
    .o_data_out (dout0),
    .o_mfc      (mfc0),
    .o_mem_err  (err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Full handshake. Address/data are scrambled after accept to prove they were latched.
  // hold > 0 keeps MFA high that many extra cycles and checks MFC/DATA_OUT against hold_exp.
  task automatic xact(input bit sel, input logic r, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d, input int hold,
                      input logic [31:0] hold_exp, output logic [31:0] rdata,
                      output logic rerr, output int edges);
    logic got;
    @(negedge clk);
    rw = r; size = sz; sgn = sg; addr = a; wdata = d;
    if (sel) mfa0 = 1'b1; else mfa = 1'b1;
    edges = 0;
    got = 1'b0;
    while (edges < 20 && !got) begin
      @(posedge clk);
      #1;
      edges++;
      got = sel ? mfc0 : mfc;
      if (edges == 1) begin
        addr = ~a;
        wdata = ~d;
      end
    end
    check("mfc_rise", 32'(sel ? mfc0 : mfc), 32'd1);
    rdata = sel ? dout0 : dout;
    rerr = sel ? err0 : err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_mfc", 32'(mfc), 32'd1);
      check("hold_data", dout, hold_exp);
    end
    @(negedge clk);
    mfa = 1'b0;
    mfa0 = 1'b0;
    @(posedge clk);
    #1;
    check("mfc_fall", 32'(sel ? mfc0 : mfc), 32'd0);
    check("dout_fall", sel ? dout0 : dout, 32'd0);
  endtask

  logic [31:0] rd;
  logic        re;
  int          ne;
  logic [7:0]  pre_val [7];

  initial begin
    pre_val[0] = 8'h9C; pre_val[1] = 8'h04; pre_val[2] = 8'h40; pre_val[3] = 8'h12;
    pre_val[4] = 8'h11; pre_val[5] = 8'h33; pre_val[6] = 8'h22;

    #12;
    check("rst_mfc", 32'(mfc), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dout", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload ram[0..6] through byte writes.
    for (int i = 0; i < 7; i++) begin
      xact(1'b0, 1'b0, 2'b00, 1'b0, 32'(i), {24'd0, pre_val[i]}, 0, 32'd0, rd, re, ne);
      check("pre_err", 32'(re), 32'd0);
    end

    // 1: word read at 0, MFC on 3rd edge.
    xact(1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 0, 32'd0, rd, re, ne);
    check("t1_edges", 32'(ne), 32'd3);
    check("t1_data", rd, 32'h9C044012);
    check("t1_err", 32'(re), 32'd0);

    // 2: byte write A5 @5, signed and unsigned reads.
    xact(1'b0, 1'b0, 2'b00, 1'b0, 32'd5, 32'h000000A5, 0, 32'd0, rd, re, ne);
    check("t2_werr", 32'(re), 32'd0);
    xact(1'b0, 1'b1, 2'b00, 1'b1, 32'd5, 32'd0, 0, 32'd0, rd, re, ne);
    check("t2_sread", rd, 32'hFFFFFFA5);
    xact(1'b0, 1'b1, 2'b00, 1'b0, 32'd5, 32'd0, 0, 32'd0, rd, re, ne);
    check("t2_uread", rd, 32'h000000A5);
    check("t2_ram4", 32'(dut.ram[4]), 32'h11);
    check("t2_ram6", 32'(dut.ram[6]), 32'h22);

    // 3: misaligned half read and word write.
    xact(1'b0, 1'b1, 2'b01, 1'b0, 32'd1, 32'd0, 0, 32'd0, rd, re, ne);
    check("t3_herr", 32'(re), 32'd1);
    check("t3_hdata", rd, 32'd0);
    xact(1'b0, 1'b0, 2'b10, 1'b0, 32'd2, 32'hFFFFFFFF, 0, 32'd0, rd, re, ne);
    check("t3_werr", 32'(re), 32'd1);
    check("t3_ram2", 32'(dut.ram[2]), 32'h40);
    check("t3_ram3", 32'(dut.ram[3]), 32'h12);
    check("t3_ram4", 32'(dut.ram[4]), 32'h11);
    check("t3_ram5", 32'(dut.ram[5]), 32'hA5);

    // 4: top-of-memory word, range errors, illegal size.
    xact(1'b0, 1'b0, 2'b10, 1'b0, 32'd508, 32'hDEADBEEF, 0, 32'd0, rd, re, ne);
    check("t4_werr", 32'(re), 32'd0);
    check("t4_ram508", 32'(dut.ram[508]), 32'hDE);
    check("t4_ram509", 32'(dut.ram[509]), 32'hAD);
    check("t4_ram510", 32'(dut.ram[510]), 32'hBE);
    check("t4_ram511", 32'(dut.ram[511]), 32'hEF);
    xact(1'b0, 1'b1, 2'b10, 1'b0, 32'd508, 32'd0, 0, 32'd0, rd, re, ne);
    check("t4_rd508", rd, 32'hDEADBEEF);
    xact(1'b0, 1'b1, 2'b01, 1'b1, 32'd510, 32'd0, 0, 32'd0, rd, re, ne);
    check("t4_half510", rd, 32'hFFFFBEEF);
    xact(1'b0, 1'b1, 2'b10, 1'b0, 32'd510, 32'd0, 0, 32'd0, rd, re, ne);
    check("t4_err510", 32'(re), 32'd1);
    xact(1'b0, 1'b1, 2'b00, 1'b0, 32'd512, 32'd0, 0, 32'd0, rd, re, ne);
    check("t4_err512", 32'(re), 32'd1);
    xact(1'b0, 1'b1, 2'b00, 1'b0, 32'h10000000, 32'd0, 0, 32'd0, rd, re, ne);
    check("t4_errhi", 32'(re), 32'd1);
    xact(1'b0, 1'b1, 2'b11, 1'b0, 32'd0, 32'd0, 0, 32'd0, rd, re, ne);
    check("t4_errsz", 32'(re), 32'd1);
    check("t4_szdata", rd, 32'd0);

    // 5: hold MFA 5 extra cycles after MFC, then back-to-back reads.
    xact(1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 5, 32'h9C044012, rd, re, ne);
    check("t5_data", rd, 32'h9C044012);
    xact(1'b0, 1'b1, 2'b01, 1'b0, 32'd2, 32'd0, 0, 32'd0, rd, re, ne);
    check("t5_b2b_edges", 32'(ne), 32'd3);
    check("t5_b2b_data", rd, 32'h00004012);

    // 6a: reset during WAIT of a word write.
    @(negedge clk);
    rw = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'd0; wdata = 32'h01020304;
    mfa = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_mfc", 32'(mfc), 32'd0);
    @(negedge clk);
    mfa = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_rst_idle", 32'(mfc), 32'd0);
    xact(1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 0, 32'd0, rd, re, ne);
    check("t6_rst_ram", rd, 32'h9C044012);

    // 6b: MFA dropped in WAIT abandons the write.
    @(negedge clk);
    rw = 1'b0; size = 2'b10; addr = 32'd0; wdata = 32'hAAAAAAAA;
    mfa = 1'b1;
    @(negedge clk);
    mfa = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("t6_abandon_mfc", 32'(mfc), 32'd0);
    end
    xact(1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 0, 32'd0, rd, re, ne);
    check("t6_abandon_ram", rd, 32'h9C044012);

    // 6c: zero wait states, MFC on the accept edge.
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'd8, 32'h00000077, 0, 32'd0, rd, re, ne);
    check("t6_ws0_wedges", 32'(ne), 32'd1);
    xact(1'b1, 1'b1, 2'b00, 1'b0, 32'd8, 32'd0, 0, 32'd0, rd, re, ne);
    check("t6_ws0_redges", 32'(ne), 32'd1);
    check("t6_ws0_byte", rd, 32'h00000077);
    xact(1'b1, 1'b0, 2'b10, 1'b0, 32'd12, 32'h80000001, 0, 32'd0, rd, re, ne);
    xact(1'b1, 1'b1, 2'b01, 1'b1, 32'd12, 32'd0, 0, 32'd0, rd, re, ne);
    check("t6_ws0_half", rd, 32'hFFFF8000);
    xact(1'b1, 1'b1, 2'b10, 1'b0, 32'd13, 32'd0, 0, 32'd0, rd, re, ne);
    check("t6_ws0_err", 32'(re), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
